pll_lock_sequencer: RTL and testbench
=====================================

Name: pll_lock_sequencer

Overview:
Controls the reset/lock interface of the miner core PLL: drives the PLL reset input, watches the PLL locked output, and holds the downstream hashing-core reset until lock has stayed stable. Runs on the 50 MHz board reference clock, which also feeds the PLL. It retries a failed lock a bounded number of times, then latches a failure flag. Downstream logic re-synchronizes `core_rst_n` into the PLL output domain.

Parameters:
RST_PULSE_CYCLES, 16, cycles pll_rst is held high per reset attempt (≥1)
LOCK_TIMEOUT_CYCLES, 50000, cycles to wait for lock after pll_rst release (1 ms @ 50 MHz)
STABLE_CYCLES, 1024, consecutive synchronized-locked cycles required before core release
MAX_RETRIES, 7, reset attempts allowed after the first before FAIL
SYNC_STAGES, 2, synchronizer depth on pll_locked (≥2)

Ports:
refclk  in  1  reference clock, 50 MHz; sole clock
rst_n  in  1  asynchronous active-low reset
pll_locked  in  1  PLL locked output; asynchronous to refclk
relock_req  in  1  single-cycle request to restart the lock sequence (e.g. after reprogramming)
pll_rst  out  1  PLL reset, active high
core_rst_n  out  1  downstream core reset, active low
lock_ok  out  1  high only in RUN
lock_fail  out  1  high only in FAIL
retry_count  out  $clog2(MAX_RETRIES+1)  retries used in the current episode

Behaviour:
- Reset is asynchronous and active-low; one clock, refclk. While rst_n=0: state=RESET_PLL, pll_rst=1, core_rst_n=0, lock_ok=0, lock_fail=0, retry_count=0, all counters 0, synchronizer cleared to 0.
- pll_locked passes through a SYNC_STAGES flop chain to produce locked_s. A rise on pll_locked is visible on locked_s SYNC_STAGES cycles later.
- All outputs are registered and update in the same edge as the state. No combinational path from inputs to outputs.
- A single cycle counter is cleared on every state transition.
- RESET_PLL: pll_rst=1, core_rst_n=0. After RST_PULSE_CYCLES cycles in this state, go to WAIT_LOCK.
- WAIT_LOCK: pll_rst=0.
  - If locked_s=1, go to STABILIZE.
  - Otherwise, when the counter reaches LOCK_TIMEOUT_CYCLES-1, take the retry path.
- STABILIZE: pll_rst=0.
  - If locked_s=0 on any cycle, take the retry path.
  - After STABLE_CYCLES consecutive cycles with locked_s=1, go to RUN.
- Retry path: if retry_count==MAX_RETRIES, go to FAIL. Otherwise retry_count+1 and go to RESET_PLL.
- RUN: core_rst_n=1, lock_ok=1, pll_rst=0.
  - If locked_s=0, go to RESET_PLL with retry_count=0 (a new episode).
  - core_rst_n falls on the same edge that leaves RUN.
- FAIL: pll_rst=1, core_rst_n=0, lock_fail=1. This state is sticky; it exits only on relock_req or rst_n.
- relock_req=1 has highest priority in every state: go to RESET_PLL, retry_count=0, counter=0. relock_req in RESET_PLL restarts the pulse count.
- Latency from the pll_locked rise, sampled in WAIT_LOCK, to core_rst_n=1 is exactly SYNC_STAGES+1+STABLE_CYCLES cycles.
- retry_count saturates at MAX_RETRIES and never wraps.
- The counter width must hold max(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, STABLE_CYCLES).
- core_rst_n is never 1 while pll_rst=1.
- Simultaneous events: if locked_s rises on the timeout cycle in WAIT_LOCK, lock wins and the state goes to STABILIZE.
- Reset asserted mid-operation, in any state: outputs go to reset values immediately, with no clock edge required.

Test Plan:
Bench parameters: RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, STABLE_CYCLES=8, MAX_RETRIES=2, SYNC_STAGES=2.
1. Normal lock: release rst_n, raise pll_locked 5 cycles after pll_rst falls -> pll_rst high exactly 4 cycles; core_rst_n and lock_ok rise exactly 11 cycles after the pll_locked rise; retry_count=0.
2. Never locks: hold pll_locked=0 -> three 4-cycle pll_rst pulses separated by 20 low cycles; retry_count steps 0,1,2; then lock_fail=1, pll_rst=1 held, core_rst_n=0 for at least 200 further cycles.
3. Glitch during stabilize: lock, then drop pll_locked for 1 cycle 3 cycles into STABILIZE -> new pll_rst pulse; retry_count=1; core_rst_n stays 0 throughout; a clean relock then reaches RUN.
4. Loss of lock in RUN: after case 1, drop pll_locked -> core_rst_n=0 and lock_ok=0 exactly 3 cycles later, together with pll_rst=1; retry_count=0.
5. relock_req: pulse it in FAIL -> lock_fail=0, pll_rst 4-cycle pulse, retry_count=0. Pulse it in RUN -> core_rst_n=0 on the next edge.
6. Async reset: drop rst_n between edges mid-STABILIZE -> pll_rst=1, core_rst_n=0 and retry_count=0 immediately; normal sequence resumes after release.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses the PLL reset, waits for a stable lock, then releases
// the downstream core reset. Failed locks are retried a bounded number of times before a sticky failure.
module pll_lock_sequencer #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int STABLE_CYCLES       = 1024,
  parameter int MAX_RETRIES         = 7,
  parameter int SYNC_STAGES         = 2,
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic          refclk,
  input  logic          rst_n,
  input  logic          pll_locked,
  input  logic          relock_req,
  output logic          pll_rst,
  output logic          core_rst_n,
  output logic          lock_ok,
  output logic          lock_fail,
  output logic [RW-1:0] retry_count
);

  localparam int MAX_AB  = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ? RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_CNT = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int CW      = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] PULSE_LAST   = CW'(RST_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABILIZE,
    RUN,
    FAIL
  } state_t;

  state_t                 state;
  logic [CW-1:0]          count;
  logic [SYNC_STAGES-1:0] sync;
  logic                   locked_s;

  assign locked_s = sync[SYNC_STAGES-1];

  // Output pattern {pll_rst, core_rst_n, lock_ok, lock_fail} for the state being entered,
  // so outputs are registered alongside the state itself.
  function automatic logic [3:0] outs_for(input state_t s);
    case (s)
      RESET_PLL: outs_for = 4'b1000;
      RUN:       outs_for = 4'b0110;
      FAIL:      outs_for = 4'b1001;
      default:   outs_for = 4'b0000;
    endcase
  endfunction

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RESET_PLL;
      {pll_rst, core_rst_n, lock_ok, lock_fail} <= outs_for(RESET_PLL);
      count       <= '0;
      retry_count <= '0;
      sync        <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pll_locked};
      if (relock_req) begin
        state       <= RESET_PLL;
        {pll_rst, core_rst_n, lock_ok, lock_fail} <= outs_for(RESET_PLL);
        count       <= '0;
        retry_count <= '0;
      end else begin
        case (state)
          RESET_PLL: begin
            if (count == PULSE_LAST) begin
              state <= WAIT_LOCK;
              {pll_rst, core_rst_n, lock_ok, lock_fail} <= outs_for(WAIT_LOCK);
              count <= '0;
            end else begin
              count <= count + 1'b1;
            end
          end
          WAIT_LOCK: begin
            // A lock seen on the timeout cycle still counts as a lock.
            if (locked_s) begin
              state <= STABILIZE;
              {pll_rst, core_rst_n, lock_ok, lock_fail} <= outs_for(STABILIZE);
              count <= '0;
            end else if (count == TIMEOUT_LAST) begin
              count <= '0;
              if (retry_count == RETRY_MAX) begin
                state <= FAIL;
                {pll_rst, core_rst_n, lock_ok, lock_fail} <= outs_for(FAIL);
              end else begin
                state       <= RESET_PLL;
                {pll_rst, core_rst_n, lock_ok, lock_fail} <= outs_for(RESET_PLL);
                retry_count <= retry_count + 1'b1;
              end
            end else begin
              count <= count + 1'b1;
            end
          end
          STABILIZE: begin
            if (!locked_s) begin
              count <= '0;
              if (retry_count == RETRY_MAX) begin
                state <= FAIL;
                {pll_rst, core_rst_n, lock_ok, lock_fail} <= outs_for(FAIL);
              end else begin
                state       <= RESET_PLL;
                {pll_rst, core_rst_n, lock_ok, lock_fail} <= outs_for(RESET_PLL);
                retry_count <= retry_count + 1'b1;
              end
            end else if (count == STABLE_LAST) begin
              state <= RUN;
              {pll_rst, core_rst_n, lock_ok, lock_fail} <= outs_for(RUN);
              count <= '0;
            end else begin
              count <= count + 1'b1;
            end
          end
          RUN: begin
            // Losing lock while running starts a fresh episode with a clean retry budget.
            if (!locked_s) begin
              state       <= RESET_PLL;
              {pll_rst, core_rst_n, lock_ok, lock_fail} <= outs_for(RESET_PLL);
              count       <= '0;
              retry_count <= '0;
            end
          end
          FAIL: begin
            count <= '0;
          end
          default: begin
            state       <= RESET_PLL;
            {pll_rst, core_rst_n, lock_ok, lock_fail} <= outs_for(RESET_PLL);
            count       <= '0;
            retry_count <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: table-driven lock/loss vectors, directed corner sequences,
// then randomized pll_locked/relock_req/rst_n traffic checked every cycle against a phase/age model.
module tb_pll_lock_sequencer;

  localparam int P_PULSE   = 4;
  localparam int P_TIMEOUT = 20;
  localparam int P_STABLE  = 8;
  localparam int P_RETRIES = 2;
  localparam int P_SYNC    = 2;
  localparam int RW        = $clog2(P_RETRIES + 1);

  logic          refclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pll_locked = 1'b0;
  logic          relock_req = 1'b0;
  logic          pll_rst, core_rst_n, lock_ok, lock_fail;
  logic [RW-1:0] retry_count;

  int errors = 0;
  int checks = 0;

  pll_lock_sequencer #(
    .RST_PULSE_CYCLES   (P_PULSE),
    .LOCK_TIMEOUT_CYCLES(P_TIMEOUT),
    .STABLE_CYCLES      (P_STABLE),
    .MAX_RETRIES        (P_RETRIES),
    .SYNC_STAGES        (P_SYNC)
  ) dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .relock_req (relock_req),
    .pll_rst    (pll_rst),
    .core_rst_n (core_rst_n),
    .lock_ok    (lock_ok),
    .lock_fail  (lock_fail),
    .retry_count(retry_count)
  );

  always #5 refclk = ~refclk;

  // Reference model: which phase we are in, how many edges spent there, retries used.
  typedef enum int {PH_PULSE, PH_WAIT, PH_STAB, PH_RUN, PH_FAIL} phase_e;
  phase_e m_phase;
  int     m_age;
  int     m_retry;
  bit     lq[$];

  function automatic void model_reset();
    m_phase = PH_PULSE;
    m_age   = 0;
    m_retry = 0;
    lq.delete();
    for (int i = 0; i < P_SYNC; i++) lq.push_back(1'b0);
  endfunction

  function automatic void enter(input phase_e p);
    m_phase = p;
    m_age   = 0;
  endfunction

  function automatic void retry_or_fail();
    if (m_retry >= P_RETRIES) enter(PH_FAIL);
    else begin
      m_retry = m_retry + 1;
      enter(PH_PULSE);
    end
  endfunction

  function automatic void model_step();
    bit ls;
    ls = lq.pop_front();
    lq.push_back(pll_locked);
    m_age = m_age + 1;
    if (relock_req) begin
      m_retry = 0;
      enter(PH_PULSE);
    end else begin
      case (m_phase)
        PH_PULSE: if (m_age == P_PULSE) enter(PH_WAIT);
        PH_WAIT:  if (ls) enter(PH_STAB); else if (m_age == P_TIMEOUT) retry_or_fail();
        PH_STAB:  if (!ls) retry_or_fail(); else if (m_age == P_STABLE) enter(PH_RUN);
        PH_RUN:   if (!ls) begin m_retry = 0; enter(PH_PULSE); end
        default:  ;
      endcase
    end
  endfunction

  function automatic logic [RW+3:0] model_status();
    model_status = {(m_phase == PH_PULSE) || (m_phase == PH_FAIL), m_phase == PH_RUN,
                    m_phase == PH_RUN, m_phase == PH_FAIL, RW'(m_retry)};
  endfunction

  function automatic logic [RW+3:0] dut_status();
    dut_status = {pll_rst, core_rst_n, lock_ok, lock_fail, retry_count};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: DUT and model both consume the inputs present at the edge; compare at negedge.
  task automatic tick();
    @(posedge refclk);
    if (rst_n) model_step();
    @(negedge refclk);
    chk("model_status{rst,core,ok,fail,retry}", 32'(dut_status()), 32'(model_status()));
  endtask

  task automatic run_len(input logic level, output int n);
    n = 0;
    while (pll_rst === level && n < 100) begin
      n++;
      tick();
    end
  endtask

  task automatic wait_phase(input phase_e p, input int maxc, input string name);
    int n;
    n = 0;
    while (m_phase != p && n < maxc) begin
      tick();
      n++;
    end
    chk(name, 32'(m_phase == p), 32'd1);
  endtask

  task automatic wait_core(input int maxc, input string name);
    int n;
    n = 0;
    while (core_rst_n !== 1'b1 && n < maxc) begin
      tick();
      n++;
    end
    chk(name, 32'(core_rst_n), 32'd1);
  endtask

  task automatic async_reset(input string name);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk(name, 32'(dut_status()), 32'({4'b1000, RW'(0)}));
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    int    n;
    bit    locked;
    bit    relock;
    bit    e_rst, e_core, e_ok, e_fail;
    int    e_retry;
    string name;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(input int n, input bit l, input bit r, input bit er, input bit ec,
                              input bit eo, input bit ef, input int et, input string nm);
    vec_t v;
    v.n = n; v.locked = l; v.relock = r;
    v.e_rst = er; v.e_core = ec; v.e_ok = eo; v.e_fail = ef; v.e_retry = et; v.name = nm;
    return v;
  endfunction

  initial begin
    int n;
    int bad;
    model_reset();
    repeat (3) @(negedge refclk);
    chk("reset_state", 32'(dut_status()), 32'({4'b1000, RW'(0)}));
    rst_n = 1'b1;

    // Normal lock (raise 5 cycles after pll_rst falls) then loss of lock in RUN.
    vecs.push_back(mk(3,  0, 0, 1, 0, 0, 0, 0, "pulse_cycle3"));
    vecs.push_back(mk(1,  0, 0, 0, 0, 0, 0, 0, "pulse_end4"));
    vecs.push_back(mk(4,  0, 0, 0, 0, 0, 0, 0, "wait_before_lock"));
    vecs.push_back(mk(10, 1, 0, 0, 0, 0, 0, 0, "lock_plus10"));
    vecs.push_back(mk(1,  1, 0, 0, 1, 1, 0, 0, "lock_plus11_run"));
    vecs.push_back(mk(5,  1, 0, 0, 1, 1, 0, 0, "run_hold"));
    vecs.push_back(mk(2,  0, 0, 0, 1, 1, 0, 0, "loss_plus2"));
    vecs.push_back(mk(1,  0, 0, 1, 0, 0, 0, 0, "loss_plus3"));
    foreach (vecs[i]) begin
      pll_locked = vecs[i].locked;
      relock_req = vecs[i].relock;
      repeat (vecs[i].n) tick();
      chk(vecs[i].name, 32'(dut_status()),
          32'({vecs[i].e_rst, vecs[i].e_core, vecs[i].e_ok, vecs[i].e_fail, RW'(vecs[i].e_retry)}));
      $display("vec %0d %s: status=%b", i, vecs[i].name, dut_status());
    end

    // Never locks: three pulses with 20-cycle gaps, then sticky failure.
    for (int p = 0; p < 3; p++) begin
      chk("retry_during_pulse", 32'(retry_count), 32'(p));
      run_len(1'b1, n);
      chk("pulse_len", 32'(n), 32'(P_PULSE));
      run_len(1'b0, n);
      chk("gap_len", 32'(n), 32'(P_TIMEOUT));
      $display("step never_lock pulse %0d done", p);
    end
    chk("fail_status", 32'(dut_status()), 32'({4'b1001, RW'(P_RETRIES)}));
    bad = 0;
    repeat (200) begin
      tick();
      if (pll_rst !== 1'b1 || core_rst_n !== 1'b0 || lock_fail !== 1'b1) bad++;
    end
    chk("fail_sticky_bad_cycles", 32'(bad), 32'd0);

    // relock_req in FAIL, then lock and relock_req in RUN.
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    chk("relock_from_fail", 32'(dut_status()), 32'({4'b1000, RW'(0)}));
    run_len(1'b1, n);
    chk("relock_pulse_len", 32'(n), 32'(P_PULSE));
    pll_locked = 1'b1;
    wait_core(60, "reach_run_after_fail");
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    chk("relock_in_run", 32'(dut_status()), 32'({4'b1000, RW'(0)}));
    $display("step relock done");

    // One-cycle glitch three cycles into STABILIZE, then a clean relock to RUN.
    wait_phase(PH_STAB, 30, "reach_stabilize");
    tick();
    tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    bad = 0;
    n = 0;
    while (pll_rst !== 1'b1 && n < 20) begin
      if (core_rst_n !== 1'b0) bad++;
      tick();
      n++;
    end
    chk("glitch_retry_pulse", 32'(pll_rst), 32'd1);
    chk("glitch_retry_count", 32'(retry_count), 32'd1);
    chk("glitch_core_held", 32'(bad), 32'd0);
    wait_core(60, "glitch_then_run");
    chk("run_retry_kept", 32'(retry_count), 32'd1);
    $display("step glitch done");

    // Async reset between edges mid-STABILIZE, then lock arriving exactly on the timeout cycle.
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    wait_phase(PH_STAB, 30, "reach_stabilize2");
    tick();
    tick();
    pll_locked = 1'b0;
    async_reset("async_reset_immediate");
    wait_phase(PH_WAIT, 20, "reach_wait_after_reset");
    while (m_age < P_TIMEOUT - 3) tick();
    pll_locked = 1'b1;
    tick();
    tick();
    chk("wait_before_timeout_edge", 32'(pll_rst), 32'd0);
    tick();
    chk("lock_wins_over_timeout", 32'({pll_rst, retry_count}), 32'({1'b0, RW'(0)}));
    wait_core(30, "run_after_reset");
    $display("step async_reset and timeout race done");

    // Randomized traffic against the model.
    for (int blk = 0; blk < 40; blk++) begin
      int mode;
      mode = $urandom_range(0, 2);
      for (int c = 0; c < 100; c++) begin
        case (mode)
          0:       if ($urandom_range(0, 39) == 0) pll_locked = ~pll_locked;
          1:       pll_locked = ($urandom_range(0, 99) == 0);
          default: pll_locked = ($urandom_range(0, 3) != 0);
        endcase
        relock_req = ($urandom_range(0, 149) == 0);
        if ($urandom_range(0, 499) == 0) begin
          relock_req = 1'b0;
          async_reset("random_async_reset");
        end else begin
          tick();
        end
      end
      $display("random block %0d mode %0d: status=%b", blk, mode, dut_status());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
